// File: rtl/bus_pkg.sv
// Shared constants for the Apple-1 CPU bus fabric: default widths, the stock
// address map and the stall FSM encoding.
package bus_pkg;

  localparam int BUS_AW        = 16;
  localparam int BUS_DW        = 8;
  localparam int APPLE1_SLAVES = 8;

  localparam int REG_RAM   = 0;
  localparam int REG_VGA   = 1;
  localparam int REG_UART  = 2;
  localparam int REG_MODE  = 3;
  localparam int REG_BASIC = 4;
  localparam int REG_WOZ   = 5;

  // VGA sits below UART so that 0xD012 reaches the display, not the UART window.
  // Regions 6 and 7 mirror WozMon and are always shadowed by region 5.
  localparam logic [APPLE1_SLAVES*BUS_AW-1:0] APPLE1_BASE = {
    16'hFF00, 16'hFF00, 16'hFF00, 16'hE000,
    16'hC000, 16'hD010, 16'hD012, 16'h0000
  };
  localparam logic [APPLE1_SLAVES*BUS_AW-1:0] APPLE1_MASK = {
    16'hFF00, 16'hFF00, 16'hFF00, 16'hF000,
    16'hF000, 16'hFFFC, 16'hFFFE, 16'hE000
  };

  typedef enum logic {ST_IDLE, ST_WAIT} fab_state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Priority address decoder: lowest matching region index wins, so the select
// vector is always one-hot or zero.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = APPLE1_SLAVES,
  parameter int AW = BUS_AW,
  parameter int IW = 3,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = APPLE1_BASE,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = APPLE1_MASK
) (
  input  logic [AW-1:0]         ab,
  output logic [NUM_SLAVES-1:0] cs,
  output logic                  hit,
  output logic [IW-1:0]         idx
);

  always_comb begin
    cs  = '0;
    hit = 1'b0;
    idx = '0;
    // Scan downwards so the last (lowest-index) match is the one that sticks.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((ab & SLAVE_MASK[i*AW +: AW]) == (SLAVE_BASE[i*AW +: AW] & SLAVE_MASK[i*AW +: AW])) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
    if (hit) cs[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_fabric.sv
// CPU-side bus fabric: region decode, per-region wait states on ready,
// single-commit slave strobes, read mux and an unmapped-access fault record.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = APPLE1_SLAVES,
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW,
  parameter int WAIT_W = 3,
  parameter logic [NUM_SLAVES*AW-1:0]     SLAVE_BASE = APPLE1_BASE,
  parameter logic [NUM_SLAVES*AW-1:0]     SLAVE_MASK = APPLE1_MASK,
  parameter logic [NUM_SLAVES*WAIT_W-1:0] SLAVE_WAIT = '0,
  parameter logic [DW-1:0]                UNMAPPED_DATA = DW'(8'hFF)
) (
  input  logic                       clk25,
  input  logic                       rst,
  input  logic                       cpu_clken,
  input  logic [AW-1:0]              ab,
  input  logic                       we,
  output logic                       ready,
  output logic [DW-1:0]              dbi,
  output logic [NUM_SLAVES-1:0]      slave_cs,
  output logic [NUM_SLAVES-1:0]      slave_en,
  output logic [NUM_SLAVES-1:0]      slave_wen,
  input  logic [NUM_SLAVES*DW-1:0]   slave_dout,
  input  logic                       fault_clr,
  output logic                       fault_valid,
  output logic [AW-1:0]              fault_addr,
  output logic                       fault_we,
  output logic [7:0]                 fault_count
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              hit;
  logic [IW-1:0]     idx;
  logic [WAIT_W-1:0] hit_wait;
  logic              same_sel;
  logic              commit;
  logic              fault_commit;

  fab_state_t        state;
  logic [WAIT_W-1:0] cnt;
  logic [IW-1:0]     sel_q;

  bus_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .AW(AW),
    .IW(IW),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (
    .ab(ab),
    .cs(slave_cs),
    .hit(hit),
    .idx(idx)
  );

  assign hit_wait = hit ? SLAVE_WAIT[int'(idx)*WAIT_W +: WAIT_W] : '0;
  assign same_sel = hit && (idx == sel_q);

  // A stalled access whose address moved away never reports ready, so it cannot commit.
  always_comb begin
    ready = !(hit_wait != '0);
    if (state == ST_WAIT) ready = same_sel && (cnt == '0);
  end

  always_comb begin
    dbi = UNMAPPED_DATA;
    if (hit) dbi = slave_dout[int'(idx)*DW +: DW];
  end

  assign commit       = ready & cpu_clken;
  assign slave_en     = commit ? slave_cs : '0;
  assign slave_wen    = we ? slave_en : '0;
  assign fault_commit = commit & ~hit;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_clken && (hit_wait != '0)) begin
            state <= ST_WAIT;
            cnt   <= hit_wait - 1'b1;
            sel_q <= idx;
          end
        end
        ST_WAIT: begin
          if (!same_sel) begin
            state <= ST_IDLE;
          end else if (cpu_clken) begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A fault commit outranks a simultaneous clear: the record restarts at this access.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_we    <= 1'b0;
      fault_count <= '0;
    end else if (fault_commit) begin
      if (fault_clr || !fault_valid) begin
        fault_addr <= ab;
        fault_we   <= we;
      end
      fault_valid <= 1'b1;
      fault_count <= fault_clr ? 8'd1 : sat_inc8(fault_count);
    end else if (fault_clr) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_we    <= 1'b0;
      fault_count <= '0;
    end
  end

endmodule
